// File: rtl/alu_iterative_m.sv
// Execute-stage ALU: single-cycle base ops plus an iterative radix-2 MUL/DIV/REM unit.
// Latency: 1 cycle for base ops and divide fast paths, WIDTH+1 cycles for multiply/divide.
// Backpressure: In_Ready only in IDLE; results are not stalled, Out_Valid is a one-cycle pulse.
module alu_iterative_m #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Flush,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [3:0]       ALU_Cntrl,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  output logic             Out_Valid,
  output logic [WIDTH-1:0] ALU_Result,
  output logic             Zero
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_REMU  = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_MUL   = 4'b1001;
  localparam logic [3:0] OP_MULH  = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_DIV   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;
  localparam logic [3:0] OP_REM   = 4'b1111;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic                 zero_q, zero_d;
  logic                 ovld_q, ovld_d;

  logic                 accept;
  logic                 in_is_mul, in_is_div, in_signed, div0, ovf;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag, quick_res;

  logic                 q_is_mul;
  logic [WIDTH:0]       mul_sum, div_shl, div_diff;
  logic                 qbit;
  logic [2*WIDTH-1:0]   step, prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix, final_res;

  assign In_Ready   = (state_q == S_IDLE);
  assign Out_Valid  = ovld_q;
  assign ALU_Result = res_q;
  assign Zero       = zero_q;
  assign accept     = In_Valid & (state_q == S_IDLE) & ~Flush;

  // Decode the incoming op, form operand magnitudes and the one-cycle result.
  always_comb begin
    in_is_mul = (ALU_Cntrl == OP_MUL) | (ALU_Cntrl == OP_MULH) | (ALU_Cntrl == OP_MULHU);
    in_is_div = (ALU_Cntrl == OP_DIV) | (ALU_Cntrl == OP_DIVU) |
                (ALU_Cntrl == OP_REM) | (ALU_Cntrl == OP_REMU);
    in_signed = (ALU_Cntrl == OP_MUL) | (ALU_Cntrl == OP_MULH) |
                (ALU_Cntrl == OP_DIV) | (ALU_Cntrl == OP_REM);
    a_neg     = in_signed & In1[WIDTH-1];
    b_neg     = in_signed & In2[WIDTH-1];
    a_mag     = a_neg ? -In1 : In1;
    b_mag     = b_neg ? -In2 : In2;
    div0      = in_is_div & (In2 == '0);
    ovf       = ((ALU_Cntrl == OP_DIV) | (ALU_Cntrl == OP_REM)) & (In1 == MOST_NEG) & (In2 == '1);
    quick_res = '0;
    case (ALU_Cntrl)
      OP_AND:  quick_res = In1 & In2;
      OP_OR:   quick_res = In1 | In2;
      OP_ADD:  quick_res = In1 + In2;
      OP_XOR:  quick_res = In1 ^ In2;
      OP_SUB:  quick_res = In1 - In2;
      OP_NOR:  quick_res = ~(In1 | In2);
      OP_SLT:  quick_res = {{(WIDTH-1){1'b0}}, ($signed(In1) < $signed(In2))};
      OP_SLTU: quick_res = {{(WIDTH-1){1'b0}}, (In1 < In2)};
      // Divide-by-zero gives all ones; signed overflow returns the dividend.
      OP_DIV, OP_DIVU: quick_res = div0 ? '1 : In1;
      // Divide-by-zero returns the dividend; signed overflow remainder is zero.
      OP_REM, OP_REMU: quick_res = div0 ? In1 : '0;
      default: quick_res = '0;
    endcase
  end

  // One shift-add or restoring-divide step, plus sign fix-up of the finished value.
  always_comb begin
    q_is_mul = (op_q == OP_MUL) | (op_q == OP_MULH) | (op_q == OP_MULHU);
    // Multiply: acc = {partial high, remaining multiplier bits}.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
    div_shl  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_shl - {1'b0, opnd_q};
    qbit     = ~div_diff[WIDTH];
    if (q_is_mul) begin
      step = {mul_sum, acc_q[WIDTH-1:1]};
    end else begin
      step = {(qbit ? div_diff[WIDTH-1:0] : div_shl[WIDTH-1:0]), acc_q[WIDTH-2:0], qbit};
    end
    prod_fix = neg_q ? -step : step;
    quo_fix  = neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
    rem_fix  = rneg_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
    case (op_q)
      OP_MUL:             final_res = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHU:  final_res = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:    final_res = quo_fix;
      default:            final_res = rem_fix;
    endcase
  end

  // Next-state for the IDLE/BUSY/DONE sequencer and all datapath registers.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ovld_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = ALU_Cntrl;
          if (in_is_mul | (in_is_div & ~div0 & ~ovf)) begin
            state_d = S_BUSY;
            cnt_d   = '0;
            acc_d   = in_is_mul ? {{WIDTH{1'b0}}, b_mag} : {{WIDTH{1'b0}}, a_mag};
            opnd_d  = in_is_mul ? a_mag : b_mag;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
          end else begin
            state_d = S_DONE;
            res_d   = quick_res;
            zero_d  = (quick_res == '0);
            ovld_d  = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (Flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_d = S_DONE;
            cnt_d   = '0;
            res_d   = final_res;
            zero_d  = (final_res == '0);
            ovld_d  = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovld_q  <= ovld_d;
    end
  end

endmodule
